// File: rtl/dsp_pkg.sv
// -----------------------------------------------------------------------------
// dsp_pkg
// Shared definitions for the audio DSP chain: default sample width (shared
// between the I2S receiver and the FIR filter), channel tag encoding and the
// I2S receiver state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package dsp_pkg;

   // Default sample width; the filter stage is built with the same value.
   localparam int SAMP_WIDTH_DEF = 24;

   typedef enum logic {
      CH_LEFT  = 1'b0,
      CH_RIGHT = 1'b1
   } chan_t;

   typedef enum logic [1:0] {
      SYNC,
      ARM,
      SHIFT,
      SKIP
   } i2s_rx_state_t;

endpackage

// File: rtl/cdc_sync_bit.sv
// -----------------------------------------------------------------------------
// cdc_sync_bit
// Multi-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk  - destination clock
//   rst  - synchronous active-high reset (chain cleared to 0)
//   d    - asynchronous input
//   q    - synchronized output, SYNC_STAGES clk cycles behind d
// -----------------------------------------------------------------------------
module cdc_sync_bit #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] stage_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_reg <= '0;
      end else begin
         stage_reg <= {stage_reg[SYNC_STAGES-2:0], d};
      end
   end

   assign q = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_rx_deserializer.sv
// -----------------------------------------------------------------------------
// i2s_rx_deserializer
// Front end of the audio DSP chain. Synchronizes an asynchronous I2S stream,
// deserializes each channel slot MSB-first into a SAMP_WIDTH-bit word and
// presents it with a one-cycle valid strobe and a channel tag.
// Ports:
//   clk         - system clock (>= 4x i2s_bclk)
//   rst         - synchronous active-high reset
//   i2s_bclk    - I2S bit clock (async)
//   i2s_lrclk   - I2S word select, 0 = left, 1 = right (async)
//   i2s_sdata   - I2S serial data, MSB first (async)
//   out_sample  - last deserialized sample, held between strobes
//   out_valid   - one-cycle strobe for a new out_sample
//   out_channel - channel of out_sample, 0 = left, 1 = right
//   frame_err   - sticky short-slot flag, cleared only by rst
// -----------------------------------------------------------------------------
module i2s_rx_deserializer
   import dsp_pkg::*;
#(
   parameter int SAMP_WIDTH  = SAMP_WIDTH_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i2s_bclk,
   input  logic                  i2s_lrclk,
   input  logic                  i2s_sdata,
   output logic [SAMP_WIDTH-1:0] out_sample,
   output logic                  out_valid,
   output logic                  out_channel,
   output logic                  frame_err
);

   localparam int               CNT_W    = $clog2(SAMP_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SAMP_WIDTH);

   // ---------------------------------------------------------------------
   // Input synchronizers: bit 0 = bclk, bit 1 = lrclk, bit 2 = sdata
   // ---------------------------------------------------------------------
   logic [2:0] pin_vec;
   logic [2:0] sync_vec;
   logic       bclk_s;
   logic       lrclk_s;
   logic       sdata_s;

   assign pin_vec = {i2s_sdata, i2s_lrclk, i2s_bclk};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_sync
         cdc_sync_bit #(
            .SYNC_STAGES(SYNC_STAGES)
         ) u_sync (
            .clk(clk),
            .rst(rst),
            .d  (pin_vec[gi]),
            .q  (sync_vec[gi])
         );
      end
   endgenerate

   assign bclk_s  = sync_vec[0];
   assign lrclk_s = sync_vec[1];
   assign sdata_s = sync_vec[2];

   // ---------------------------------------------------------------------
   // bclk rising-edge detect. The pulse is registered, so it lands
   // SYNC_STAGES+1 cycles after the pin edge. lrclk/sdata are read one
   // cycle after their own synchronizers caught the rising edge; they are
   // still stable then because bclk stays high for at least 2 clk cycles.
   // ---------------------------------------------------------------------
   logic bclk_d_reg;
   logic bclk_rise_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         bclk_d_reg    <= 1'b0;
         bclk_rise_reg <= 1'b0;
      end else begin
         bclk_d_reg    <= bclk_s;
         bclk_rise_reg <= bclk_s & ~bclk_d_reg;
      end
   end

   // ---------------------------------------------------------------------
   // Deserializer FSM, shift register and output registers
   // ---------------------------------------------------------------------
   i2s_rx_state_t         state_reg;
   logic                  primed_reg;   // lr_prev holds a real sampled value
   logic                  lr_prev_reg;
   logic [CNT_W-1:0]      bit_cnt_reg;
   logic [SAMP_WIDTH-1:0] shreg_reg;
   chan_t                 slot_ch_reg;

   logic                  lr_change;
   logic [SAMP_WIDTH-1:0] shifted;
   logic [CNT_W-1:0]      cnt_inc;

   assign lr_change = (lrclk_s != lr_prev_reg);
   // Cast drops the old MSB; written this way so SAMP_WIDTH = 1 stays legal.
   assign shifted   = SAMP_WIDTH'({shreg_reg, sdata_s});
   assign cnt_inc   = bit_cnt_reg + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= SYNC;
         primed_reg  <= 1'b0;
         lr_prev_reg <= 1'b0;
         bit_cnt_reg <= '0;
         shreg_reg   <= '0;
         slot_ch_reg <= CH_LEFT;
         out_sample  <= '0;
         out_valid   <= 1'b0;
         out_channel <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (bclk_rise_reg) begin
            lr_prev_reg <= lrclk_s;
            primed_reg  <= 1'b1;
            case (state_reg)
               SYNC: begin
                  // The first rise after reset only learns the current word
                  // select level, so releasing reset in the middle of a
                  // right slot cannot be mistaken for a slot boundary.
                  if (primed_reg && lr_change) begin
                     state_reg <= ARM;
                  end
               end
               ARM: begin
                  shreg_reg   <= SAMP_WIDTH'(sdata_s);
                  bit_cnt_reg <= CNT_W'(1);
                  slot_ch_reg <= chan_t'(lrclk_s);
                  if (SAMP_WIDTH == 1) begin
                     out_sample  <= SAMP_WIDTH'(sdata_s);
                     out_channel <= lrclk_s;
                     out_valid   <= 1'b1;
                     state_reg   <= SKIP;
                  end else begin
                     state_reg <= SHIFT;
                  end
               end
               SHIFT: begin
                  shreg_reg   <= shifted;
                  bit_cnt_reg <= cnt_inc;
                  if (lr_change) begin
                     // This rise carries the LSB of the slot in progress.
                     out_valid   <= 1'b1;
                     out_channel <= slot_ch_reg;
                     state_reg   <= ARM;
                     if (cnt_inc == CNT_FULL) begin
                        out_sample <= shifted;
                     end else begin
                        // Short slot: left-justify, zero-pad the LSBs.
                        out_sample <= shifted << (CNT_FULL - cnt_inc);
                        frame_err  <= 1'b1;
                     end
                  end else if (cnt_inc == CNT_FULL) begin
                     out_valid   <= 1'b1;
                     out_channel <= slot_ch_reg;
                     out_sample  <= shifted;
                     state_reg   <= SKIP;
                  end
               end
               SKIP: begin
                  // Slot wider than SAMP_WIDTH: drop the trailing bits.
                  if (lr_change) begin
                     state_reg <= ARM;
                  end
               end
               default: state_reg <= SYNC;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// -----------------------------------------------------------------------------
// tb_i2s_rx_deserializer
// Self-checking bench for i2s_rx_deserializer. Each test builds a list of I2S
// bit periods (slots), the expected emits are derived from the slot contents,
// and a monitor records every out_valid cycle for comparison.
// -----------------------------------------------------------------------------
module tb_i2s_rx_deserializer;

   localparam int W        = 24;
   localparam int SS       = 2;
   localparam int LAT      = SS + 2;
   localparam int N_FRAMES = 100;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         i2s_bclk = 1'b0;
   logic         i2s_lrclk = 1'b0;
   logic         i2s_sdata = 1'b0;
   logic [W-1:0] out_sample;
   logic         out_valid;
   logic         out_channel;
   logic         frame_err;

   i2s_rx_deserializer #(
      .SAMP_WIDTH (W),
      .SYNC_STAGES(SS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i2s_bclk   (i2s_bclk),
      .i2s_lrclk  (i2s_lrclk),
      .i2s_sdata  (i2s_sdata),
      .out_sample (out_sample),
      .out_valid  (out_valid),
      .out_channel(out_channel),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] sample;
      logic         ch;
      logic         err;
      int           cyc;
      int           per;
   } emit_t;

   emit_t act_q[$];
   emit_t exp_q[$];
   emit_t cap_e;
   bit    sd_q[$];
   bit    ch_q[$];
   int    lo_q[$];
   int    hi_q[$];
   int    rise_cyc[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit err_model = 1'b0;
   bit seen_emit = 1'b0;
   bit nz_flag = 1'b0;

   // Monitor: one record per out_valid cycle, sampled 1 ns after the edge.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (out_valid) begin
         cap_e.sample = out_sample;
         cap_e.ch     = out_channel;
         cap_e.err    = frame_err;
         cap_e.cyc    = cyc;
         cap_e.per    = -1;
         act_q.push_back(cap_e);
         seen_emit = 1'b1;
      end else if (!seen_emit && (out_sample != '0 || out_channel || frame_err)) begin
         nz_flag = 1'b1;
      end
   end

   task automatic clear_all();
      sd_q.delete(); ch_q.delete(); lo_q.delete(); hi_q.delete();
      act_q.delete(); exp_q.delete(); rise_cyc.delete();
      err_model = 1'b0;
      seen_emit = 1'b0;
      nz_flag   = 1'b0;
   endtask

   // Append one slot: len bits of val (MSB first) on channel ch.
   // Reference: the emitted word is the first min(len,W) bits, left-justified,
   // produced at the rise of the min(len,W)-th bit.
   task automatic add_slot(input bit ch, input int len, input logic [63:0] val,
                           input int ratio, input bit jit, input bit expect_it);
      emit_t e;
      int    n;
      int    start;
      start = sd_q.size();
      for (int i = 0; i < len; i++) begin
         int lo, hi;
         sd_q.push_back(val[len-1-i]);
         ch_q.push_back(ch);
         lo = ratio / 2;
         hi = ratio - lo;
         if (jit) begin
            lo = lo + int'($urandom_range(0, 2)) - 1;
            hi = hi + int'($urandom_range(0, 2)) - 1;
         end
         if (lo < 2) lo = 2;
         if (hi < 2) hi = 2;
         lo_q.push_back(lo);
         hi_q.push_back(hi);
      end
      if (expect_it) begin
         n = (len < W) ? len : W;
         if (len >= W) e.sample = W'(val >> (len - W));
         else          e.sample = W'(val << (W - len));
         if (len < W) err_model = 1'b1;
         e.ch  = ch;
         e.err = err_model;
         e.per = start + n - 1;
         e.cyc = 0;
         exp_q.push_back(e);
      end
   endtask

   // Play the period list. Word select changes with the data on the falling
   // edge, one bit ahead of the slot it announces.
   task automatic drive_stream(input int rel_period, input int pulse_period);
      @(negedge clk);
      for (int j = 0; j < sd_q.size(); j++) begin
         i2s_bclk  = 1'b0;
         i2s_lrclk = (j + 1 < ch_q.size()) ? ch_q[j+1] : ch_q[j];
         i2s_sdata = sd_q[j];
         if (j == rel_period)   rst = 1'b0;
         if (j == pulse_period) rst = 1'b1;
         for (int k = 0; k < lo_q[j]; k++) begin
            @(negedge clk);
            if (j == pulse_period) rst = 1'b0;
         end
         i2s_bclk = 1'b1;
         rise_cyc.push_back(cyc);
         repeat (hi_q[j]) @(negedge clk);
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic reset_dut(input bit lead_ch);
      @(negedge clk);
      rst = 1'b1; i2s_bclk = 1'b0; i2s_lrclk = lead_ch; i2s_sdata = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      clear_all();
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; i2s_bclk = 1'b0; i2s_lrclk = 1'b0; i2s_sdata = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (out_sample !== '0) begin errors++; $display("FAIL reset_sample: got %h expected 0", out_sample); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      checks++;
      if (out_channel !== 1'b0) begin errors++; $display("FAIL reset_channel: got %b expected 0", out_channel); end
      checks++;
      if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
      $display("test_reset done");
   endtask

   task automatic test_nominal();
      reset_dut(1'b1);
      add_slot(1'b1, 3, 64'h0, 8, 1'b0, 1'b0);
      add_slot(1'b0, 32, 64'h12345600, 8, 1'b0, 1'b1);
      add_slot(1'b1, 32, 64'hABCDEF00, 8, 1'b0, 1'b1);
      add_slot(1'b0, 3, 64'h0, 8, 1'b0, 1'b0);
      drive_stream(-1, -1);
      checks++;
      if (act_q.size() != exp_q.size()) begin
         errors++; $display("FAIL nominal_count: got %0d emits expected %0d", act_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < act_q.size()) begin
         checks++;
         if (act_q[i].sample !== exp_q[i].sample || act_q[i].ch !== exp_q[i].ch ||
             act_q[i].err !== exp_q[i].err || act_q[i].cyc != rise_cyc[exp_q[i].per] + LAT) begin
            errors++;
            $display("FAIL nominal_emit%0d: got %h ch%0d err%0d cyc%0d expected %h ch%0d err%0d cyc%0d",
                     i, act_q[i].sample, act_q[i].ch, act_q[i].err, act_q[i].cyc,
                     exp_q[i].sample, exp_q[i].ch, exp_q[i].err, rise_cyc[exp_q[i].per] + LAT);
         end else $display("nominal emit %0d: %h ch%0d", i, act_q[i].sample, act_q[i].ch);
      end
      checks++;
      if (frame_err !== 1'b0) begin errors++; $display("FAIL nominal_frame_err: got %b expected 0", frame_err); end
   endtask

   task automatic test_exact();
      reset_dut(1'b1);
      add_slot(1'b1, 3, 64'h0, 8, 1'b0, 1'b0);
      add_slot(1'b0, 24, 64'h800001, 8, 1'b0, 1'b1);
      add_slot(1'b1, 24, 64'h7FFFFF, 6, 1'b0, 1'b1);
      add_slot(1'b0, 3, 64'h0, 8, 1'b0, 1'b0);
      drive_stream(-1, -1);
      checks++;
      if (act_q.size() != exp_q.size()) begin
         errors++; $display("FAIL exact_count: got %0d emits expected %0d", act_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < act_q.size()) begin
         checks++;
         if (act_q[i].sample !== exp_q[i].sample || act_q[i].ch !== exp_q[i].ch ||
             act_q[i].err !== exp_q[i].err || act_q[i].cyc != rise_cyc[exp_q[i].per] + LAT) begin
            errors++;
            $display("FAIL exact_emit%0d: got %h ch%0d err%0d cyc%0d expected %h ch%0d err%0d cyc%0d",
                     i, act_q[i].sample, act_q[i].ch, act_q[i].err, act_q[i].cyc,
                     exp_q[i].sample, exp_q[i].ch, exp_q[i].err, rise_cyc[exp_q[i].per] + LAT);
         end else $display("exact emit %0d: %h ch%0d latency %0d", i, act_q[i].sample, act_q[i].ch,
                           act_q[i].cyc - rise_cyc[exp_q[i].per]);
      end
   endtask

   task automatic test_short();
      reset_dut(1'b1);
      add_slot(1'b1, 3, 64'h0, 8, 1'b0, 1'b0);
      add_slot(1'b0, 16, 64'hBEEF, 8, 1'b0, 1'b1);
      add_slot(1'b1, 16, 64'h1234, 8, 1'b0, 1'b1);
      add_slot(1'b0, 24, {32'h0, $urandom}, 8, 1'b0, 1'b1);
      add_slot(1'b1, 30, {32'h0, $urandom}, 8, 1'b0, 1'b1);
      add_slot(1'b0, 3, 64'h0, 8, 1'b0, 1'b0);
      drive_stream(-1, -1);
      checks++;
      if (act_q.size() != exp_q.size()) begin
         errors++; $display("FAIL short_count: got %0d emits expected %0d", act_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < act_q.size()) begin
         checks++;
         if (act_q[i].sample !== exp_q[i].sample || act_q[i].ch !== exp_q[i].ch ||
             act_q[i].err !== exp_q[i].err || act_q[i].cyc != rise_cyc[exp_q[i].per] + LAT) begin
            errors++;
            $display("FAIL short_emit%0d: got %h ch%0d err%0d cyc%0d expected %h ch%0d err%0d cyc%0d",
                     i, act_q[i].sample, act_q[i].ch, act_q[i].err, act_q[i].cyc,
                     exp_q[i].sample, exp_q[i].ch, exp_q[i].err, rise_cyc[exp_q[i].per] + LAT);
         end else $display("short emit %0d: %h ch%0d err%0d", i, act_q[i].sample, act_q[i].ch, act_q[i].err);
      end
      checks++;
      if (frame_err !== 1'b1) begin errors++; $display("FAIL short_sticky: got %b expected 1", frame_err); end
   endtask

   task automatic test_startup();
      @(negedge clk);
      rst = 1'b1; i2s_bclk = 1'b0; i2s_lrclk = 1'b0; i2s_sdata = 1'b0;
      repeat (3) @(negedge clk);
      clear_all();
      add_slot(1'b0, 32, {$urandom, $urandom}, 8, 1'b0, 1'b0);
      add_slot(1'b1, 32, {$urandom, $urandom}, 8, 1'b0, 1'b0);
      add_slot(1'b0, 24, {32'h0, $urandom}, 8, 1'b0, 1'b1);
      add_slot(1'b1, 28, {32'h0, $urandom}, 8, 1'b0, 1'b1);
      add_slot(1'b0, 3, 64'h0, 8, 1'b0, 1'b0);
      // Reset released 10 bits into the right slot.
      drive_stream(32 + 10, -1);
      checks++;
      if (act_q.size() != exp_q.size()) begin
         errors++; $display("FAIL startup_count: got %0d emits expected %0d", act_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < act_q.size()) begin
         checks++;
         if (act_q[i].sample !== exp_q[i].sample || act_q[i].ch !== exp_q[i].ch ||
             act_q[i].err !== exp_q[i].err || act_q[i].cyc != rise_cyc[exp_q[i].per] + LAT) begin
            errors++;
            $display("FAIL startup_emit%0d: got %h ch%0d err%0d cyc%0d expected %h ch%0d err%0d cyc%0d",
                     i, act_q[i].sample, act_q[i].ch, act_q[i].err, act_q[i].cyc,
                     exp_q[i].sample, exp_q[i].ch, exp_q[i].err, rise_cyc[exp_q[i].per] + LAT);
         end else $display("startup emit %0d: %h ch%0d", i, act_q[i].sample, act_q[i].ch);
      end
      checks++;
      if (nz_flag !== 1'b0) begin errors++; $display("FAIL startup_quiet: got nonzero outputs before first emit, expected all 0"); end
   endtask

   task automatic test_reset_mid();
      reset_dut(1'b1);
      add_slot(1'b1, 3, 64'h0, 8, 1'b0, 1'b0);
      add_slot(1'b0, 24, {32'h0, $urandom}, 8, 1'b0, 1'b1);
      add_slot(1'b1, 24, {32'h0, $urandom}, 8, 1'b0, 1'b0);
      add_slot(1'b0, 24, {32'h0, $urandom}, 8, 1'b0, 1'b1);
      add_slot(1'b1, 30, {32'h0, $urandom}, 8, 1'b0, 1'b1);
      add_slot(1'b0, 3, 64'h0, 8, 1'b0, 1'b0);
      // One-cycle reset after 10 bits of the right slot.
      drive_stream(-1, 3 + 24 + 10);
      checks++;
      if (act_q.size() != exp_q.size()) begin
         errors++; $display("FAIL resetmid_count: got %0d emits expected %0d", act_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < act_q.size()) begin
         checks++;
         if (act_q[i].sample !== exp_q[i].sample || act_q[i].ch !== exp_q[i].ch ||
             act_q[i].err !== exp_q[i].err || act_q[i].cyc != rise_cyc[exp_q[i].per] + LAT) begin
            errors++;
            $display("FAIL resetmid_emit%0d: got %h ch%0d err%0d cyc%0d expected %h ch%0d err%0d cyc%0d",
                     i, act_q[i].sample, act_q[i].ch, act_q[i].err, act_q[i].cyc,
                     exp_q[i].sample, exp_q[i].ch, exp_q[i].err, rise_cyc[exp_q[i].per] + LAT);
         end else $display("resetmid emit %0d: %h ch%0d", i, act_q[i].sample, act_q[i].ch);
      end
   endtask

   task automatic test_random();
      int len, sel;
      reset_dut(1'b1);
      add_slot(1'b1, 3, 64'h0, 8, 1'b0, 1'b0);
      for (int f = 0; f < N_FRAMES; f++) begin
         for (int c = 0; c < 2; c++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      len = int'($urandom_range(2, W - 1));
            else if (sel == 1) len = W;
            else               len = int'($urandom_range(W + 1, 34));
            add_slot(c[0], len, {$urandom, $urandom}, int'($urandom_range(4, 10)), 1'b1, 1'b1);
         end
      end
      add_slot(1'b0, 3, 64'h0, 8, 1'b0, 1'b0);
      drive_stream(-1, -1);
      checks++;
      if (act_q.size() != exp_q.size()) begin
         errors++; $display("FAIL random_count: got %0d emits expected %0d", act_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < act_q.size()) begin
         checks++;
         if (act_q[i].sample !== exp_q[i].sample || act_q[i].ch !== exp_q[i].ch ||
             act_q[i].err !== exp_q[i].err || act_q[i].cyc != rise_cyc[exp_q[i].per] + LAT) begin
            errors++;
            $display("FAIL random_emit%0d: got %h ch%0d err%0d cyc%0d expected %h ch%0d err%0d cyc%0d",
                     i, act_q[i].sample, act_q[i].ch, act_q[i].err, act_q[i].cyc,
                     exp_q[i].sample, exp_q[i].ch, exp_q[i].err, rise_cyc[exp_q[i].per] + LAT);
         end else $display("random emit %0d: %h ch%0d err%0d", i, act_q[i].sample, act_q[i].ch, act_q[i].err);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_exact();
      test_short();
      test_startup();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
